// File: rtl/stg3ex_mc_pkg.sv
// Opcode encodings, FSM states and default widths for the stage-3 execute block.
package stg3ex_mc_pkg;
  localparam int DEF_DATA_W   = 24;
  localparam int DEF_ADDR_W   = 24;
  localparam int DEF_IMM_W    = 12;
  localparam int DEF_OPC_W    = 8;
  localparam int DEF_MUL_BITS = 4;

  // High nibble is the class: 0 R, 1 RS, 2 I, 3 IS, 4 S, 5 M.
  typedef enum logic [7:0] {
    OPC_MOV   = 8'h00, OPC_ADD   = 8'h01, OPC_SUB   = 8'h02, OPC_NOT   = 8'h03,
    OPC_AND   = 8'h04, OPC_OR    = 8'h05, OPC_XOR   = 8'h06, OPC_SHL   = 8'h07,
    OPC_SHR   = 8'h08,
    OPC_ADDS  = 8'h10, OPC_SUBS  = 8'h11, OPC_SHRS  = 8'h12,
    OPC_MOVI  = 8'h20, OPC_ADDI  = 8'h21, OPC_SUBI  = 8'h22, OPC_ANDI  = 8'h23,
    OPC_ORI   = 8'h24, OPC_XORI  = 8'h25, OPC_SHLI  = 8'h26, OPC_SHRI  = 8'h27,
    OPC_MOVIS = 8'h30, OPC_ADDIS = 8'h31, OPC_SUBIS = 8'h32, OPC_SHRIS = 8'h33,
    OPC_LUI   = 8'h40, OPC_SRMOV = 8'h41,
    OPC_MUL   = 8'h50, OPC_MULHU = 8'h51
  } opc_e;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;
endpackage

// File: rtl/stg3ex_mc_if.sv
// Decode-to-execute request bus plus the registered execute result.
interface stg3ex_mc_if import stg3ex_mc_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IMM_W  = DEF_IMM_W,
  parameter int OPC_W  = DEF_OPC_W
);
  logic              iw_flush;
  logic              iw_valid;
  logic              ow_stall;
  logic [ADDR_W-1:0] iw_pc;
  logic [DATA_W-1:0] iw_instr;
  logic [OPC_W-1:0]  iw_opc;
  logic [IMM_W-1:0]  iw_imm_val;
  logic [DATA_W-1:0] iw_src_val;
  logic [DATA_W-1:0] iw_tgt_val;
  logic [DATA_W-1:0] iw_sr_val;
  logic              iw_src_is_pc;
  logic              ow_valid;
  logic [ADDR_W-1:0] ow_pc;
  logic [DATA_W-1:0] ow_instr;
  logic [DATA_W-1:0] ow_result;

  modport master (
    output iw_flush, iw_valid, iw_pc, iw_instr, iw_opc, iw_imm_val,
           iw_src_val, iw_tgt_val, iw_sr_val, iw_src_is_pc,
    input  ow_stall, ow_valid, ow_pc, ow_instr, ow_result
  );
  modport slave (
    input  iw_flush, iw_valid, iw_pc, iw_instr, iw_opc, iw_imm_val,
           iw_src_val, iw_tgt_val, iw_sr_val, iw_src_is_pc,
    output ow_stall, ow_valid, ow_pc, ow_instr, ow_result
  );
endinterface

// File: rtl/stg3ex_mc_mul_iter.sv
// Radix-2^MUL_BITS iterative unsigned multiplier; prod_o includes the current step's partial.
module stg3ex_mc_mul_iter #(
  parameter int DATA_W   = 24,
  parameter int MUL_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                step_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic                done_o,
  output logic [2*DATA_W-1:0] prod_o
);
  localparam int STEPS = DATA_W / MUL_BITS;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic [2*DATA_W-1:0] acc_q, acc_d, mcand_q, mcand_d, partial;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_BITS; i++)
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = {{DATA_W{1'b0}}, a_i};
      mplier_d = b_i;
      cnt_d    = CNT_W'(STEPS - 1);
    end else if (step_i) begin
      acc_d    = acc_q + partial;
      mcand_d  = mcand_q << MUL_BITS;
      mplier_d = mplier_q >> MUL_BITS;
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);
  assign prod_o = acc_q + partial;
endmodule

// File: rtl/stg3ex_mc.sv
// Execute stage: single-cycle ALU, upper-immediate register, iterative MUL with upstream stall.
module stg3ex_mc import stg3ex_mc_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int IMM_W    = DEF_IMM_W,
  parameter int OPC_W    = DEF_OPC_W,
  parameter int MUL_BITS = DEF_MUL_BITS
) (
  input logic         iw_clk,
  input logic         iw_rst,
  stg3ex_mc_if.slave  bus
);
  localparam int SH_W = $clog2(DATA_W);
  localparam int UI_W = DATA_W - IMM_W;

  state_e            state_q, state_d;
  logic [UI_W-1:0]   r_ui_q, r_ui_d;
  logic              vld_q, vld_d, mhi_q;
  logic [ADDR_W-1:0] pc_q, pc_d, mpc_q;
  logic [DATA_W-1:0] instr_q, instr_d, res_q, res_d, minstr_q;
  logic [DATA_W-1:0] s, t, u, x, alu_res;
  logic [SH_W-1:0]   sh_s, sh_i;
  logic              busy, is_mul, ui_load, ui_clr, mul_start, mul_done;
  logic [2*DATA_W-1:0] prod;
  opc_e              opc;

  assign opc    = opc_e'(8'(bus.iw_opc));
  assign s      = bus.iw_src_val;
  assign t      = bus.iw_tgt_val;
  assign u      = {r_ui_q, bus.iw_imm_val};
  assign x      = {{UI_W{bus.iw_imm_val[IMM_W-1]}}, bus.iw_imm_val};
  assign sh_s   = s[SH_W-1:0];
  assign sh_i   = bus.iw_imm_val[SH_W-1:0];
  assign busy   = (state_q == ST_BUSY);
  assign is_mul = (opc == OPC_MUL) || (opc == OPC_MULHU);

  // Shifts by >= DATA_W fall out of the language semantics: zero, or sign fill for >>>.
  always_comb begin
    alu_res = '0;
    ui_load = 1'b0;
    ui_clr  = 1'b0;
    case (opc)
      OPC_MOV:            alu_res = s;
      OPC_ADD, OPC_ADDS:  alu_res = s + t;
      OPC_SUB, OPC_SUBS:  alu_res = s - t;
      OPC_NOT:            alu_res = ~t;
      OPC_AND:            alu_res = s & t;
      OPC_OR:             alu_res = s | t;
      OPC_XOR:            alu_res = s ^ t;
      OPC_SHL:            alu_res = t << sh_s;
      OPC_SHR:            alu_res = t >> sh_s;
      OPC_SHRS:           alu_res = $unsigned($signed(t) >>> sh_s);
      OPC_MOVI:  begin alu_res = u;     ui_clr = 1'b1; end
      OPC_ADDI:  begin alu_res = s + u; ui_clr = 1'b1; end
      OPC_SUBI:  begin alu_res = s - u; ui_clr = 1'b1; end
      OPC_ANDI:  begin alu_res = s & u; ui_clr = 1'b1; end
      OPC_ORI:   begin alu_res = s | u; ui_clr = 1'b1; end
      OPC_XORI:  begin alu_res = s ^ u; ui_clr = 1'b1; end
      OPC_SHLI:           alu_res = s << sh_i;
      OPC_SHRI:           alu_res = s >> sh_i;
      OPC_MOVIS:          alu_res = x;
      OPC_ADDIS:          alu_res = s + x;
      OPC_SUBIS:          alu_res = s - x;
      OPC_SHRIS:          alu_res = $unsigned($signed(s) >>> sh_i);
      OPC_LUI:            ui_load = 1'b1;
      OPC_SRMOV:          alu_res = bus.iw_src_is_pc ? DATA_W'(bus.iw_pc) : bus.iw_sr_val;
      default:            alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    r_ui_d    = r_ui_q;
    vld_d     = 1'b0;
    pc_d      = pc_q;
    instr_d   = instr_q;
    res_d     = res_q;
    mul_start = 1'b0;
    if (bus.iw_flush) begin
      state_d = ST_IDLE;
      r_ui_d  = '0;
    end else if (busy) begin
      if (mul_done) begin
        state_d = ST_IDLE;
        vld_d   = 1'b1;
        pc_d    = mpc_q;
        instr_d = minstr_q;
        res_d   = mhi_q ? prod[2*DATA_W-1:DATA_W] : prod[DATA_W-1:0];
      end
    end else if (bus.iw_valid) begin
      if (is_mul) begin
        mul_start = 1'b1;
        state_d   = ST_BUSY;
      end else begin
        vld_d   = 1'b1;
        pc_d    = bus.iw_pc;
        instr_d = bus.iw_instr;
        res_d   = alu_res;
        if (ui_load)     r_ui_d = UI_W'(bus.iw_imm_val);
        else if (ui_clr) r_ui_d = '0;
      end
    end
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q <= ST_IDLE;
      r_ui_q  <= '0;
      vld_q   <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      r_ui_q  <= r_ui_d;
      vld_q   <= vld_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      res_q   <= res_d;
    end
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      mpc_q    <= '0;
      minstr_q <= '0;
      mhi_q    <= 1'b0;
    end else if (mul_start) begin
      mpc_q    <= bus.iw_pc;
      minstr_q <= bus.iw_instr;
      mhi_q    <= (opc == OPC_MULHU);
    end
  end

  stg3ex_mc_mul_iter #(.DATA_W(DATA_W), .MUL_BITS(MUL_BITS)) u_mul (
    .clk     (iw_clk),
    .rst     (iw_rst),
    .start_i (mul_start),
    .step_i  (busy),
    .a_i     (s),
    .b_i     (t),
    .done_o  (mul_done),
    .prod_o  (prod)
  );

  assign bus.ow_stall  = busy;
  assign bus.ow_valid  = vld_q;
  assign bus.ow_pc     = pc_q;
  assign bus.ow_instr  = instr_q;
  assign bus.ow_result = res_q;
endmodule

// File: tb/tb_stg3ex_mc.sv
// Bench for stg3ex_mc: directed scenarios plus random ops against an integer reference model.
module tb_stg3ex_mc;
  import stg3ex_mc_pkg::*;
  localparam longint MASK = 64'hFFFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  longint m_ui = 0;

  stg3ex_mc_if bus ();
  stg3ex_mc dut (.iw_clk(clk), .iw_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [23:0] s, input logic [23:0] t,
                       input logic [11:0] imm, input logic [23:0] pc, input logic [23:0] instr);
    bus.iw_valid = 1'b1; bus.iw_opc = op; bus.iw_src_val = s; bus.iw_tgt_val = t;
    bus.iw_imm_val = imm; bus.iw_pc = pc; bus.iw_instr = instr;
  endtask

  // Reference result from integer arithmetic; ui is the upper-immediate value before the op.
  function automatic longint ref_res(input logic [7:0] op, input longint s, input longint t,
                                     input longint imm, input longint sr, input longint pc,
                                     input bit isp, input longint ui);
    longint u, x, st, ss, r;
    int sa, ia;
    u  = ui * 4096 + imm;
    x  = (imm >= 2048) ? imm - 4096 : imm;
    st = (t >= 64'h800000) ? t - 64'h1000000 : t;
    ss = (s >= 64'h800000) ? s - 64'h1000000 : s;
    sa = int'(s % 32);
    ia = int'(imm % 32);
    case (op)
      OPC_MOV:             r = s;
      OPC_ADD, OPC_ADDS:   r = s + t;
      OPC_SUB, OPC_SUBS:   r = s - t;
      OPC_NOT:             r = MASK - t;
      OPC_AND:             r = s & t;
      OPC_OR:              r = s | t;
      OPC_XOR:             r = s ^ t;
      OPC_SHL:             r = t << sa;
      OPC_SHR:             r = t >> sa;
      OPC_SHRS:            r = st >>> sa;
      OPC_MOVI:            r = u;
      OPC_ADDI:            r = s + u;
      OPC_SUBI:            r = s - u;
      OPC_ANDI:            r = s & u;
      OPC_ORI:             r = s | u;
      OPC_XORI:            r = s ^ u;
      OPC_SHLI:            r = s << ia;
      OPC_SHRI:            r = s >> ia;
      OPC_MOVIS:           r = x;
      OPC_ADDIS:           r = s + x;
      OPC_SUBIS:           r = s - x;
      OPC_SHRIS:           r = ss >>> ia;
      OPC_SRMOV:           r = isp ? pc : sr;
      OPC_MUL:             r = s * t;
      OPC_MULHU:           r = (s * t) >> 24;
      default:             r = 0;
    endcase
    return r & MASK;
  endfunction

  task automatic test_reset();
    bus.iw_flush = 1'b0; bus.iw_valid = 1'b0; bus.iw_opc = '0; bus.iw_imm_val = '0;
    bus.iw_src_val = '0; bus.iw_tgt_val = '0; bus.iw_sr_val = '0; bus.iw_src_is_pc = 1'b0;
    bus.iw_pc = '0; bus.iw_instr = '0;
    rst = 1'b1;
    #12;
    n_chk++; if (bus.ow_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.ow_valid); end
    n_chk++; if (bus.ow_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.ow_stall); end
    n_chk++; if (bus.ow_pc !== 24'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", bus.ow_pc); end
    n_chk++; if (bus.ow_instr !== 24'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", bus.ow_instr); end
    n_chk++; if (bus.ow_result !== 24'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", bus.ow_result); end
    @(negedge clk);
    rst = 1'b0;
    m_ui = 0;
  endtask

  task automatic test_add_idle();
    drive(OPC_ADD, 24'd5, 24'd7, 12'h0, 24'h000100, 24'h123456);
    tick();
    bus.iw_valid = 1'b0;
    n_chk++; if (bus.ow_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b want 1", bus.ow_valid); end
    n_chk++; if (bus.ow_result !== 24'd12) begin n_fail++; $display("FAIL add_result got %h want c", bus.ow_result); end
    n_chk++; if (bus.ow_instr !== 24'h123456) begin n_fail++; $display("FAIL add_instr got %h want 123456", bus.ow_instr); end
    tick();
    n_chk++; if (bus.ow_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b want 0", bus.ow_valid); end
    n_chk++; if (bus.ow_result !== 24'd12 || bus.ow_pc !== 24'h100) begin
      n_fail++; $display("FAIL idle_hold got res %h pc %h want c 100", bus.ow_result, bus.ow_pc); end
  endtask

  task automatic test_lui();
    logic [23:0] want [3] = '{24'h000000, 24'hABC123, 24'h000001};
    logic [11:0] imms [3] = '{12'hABC, 12'h123, 12'h001};
    logic [7:0]  ops  [3] = '{OPC_LUI, OPC_MOVI, OPC_MOVI};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], 24'h0, 24'h0, imms[i], 24'h10 + 24'(i), 24'h0);
      tick();
      n_chk++; if (bus.ow_valid !== 1'b1 || bus.ow_result !== want[i]) begin
        n_fail++; $display("FAIL lui_seq%0d got v%b %h want v1 %h", i, bus.ow_valid, bus.ow_result, want[i]); end
    end
    bus.iw_valid = 1'b0;
    m_ui = 0;
  endtask

  task automatic test_mul();
    int cyc;
    drive(OPC_MUL, 24'h000FFF, 24'h001001, 12'h0, 24'h000200, 24'hAAAAAA);
    tick();
    drive(OPC_ADD, 24'd1, 24'd2, 12'h0, 24'h000204, 24'h0);
    for (int i = 0; i < 6; i++) begin
      n_chk++; if (bus.ow_stall !== 1'b1 || bus.ow_valid !== 1'b0) begin
        n_fail++; $display("FAIL mul_busy%0d got stall %b valid %b want 1 0", i, bus.ow_stall, bus.ow_valid); end
      tick();
    end
    n_chk++; if (bus.ow_valid !== 1'b1 || bus.ow_result !== 24'hFFFFFF || bus.ow_pc !== 24'h200) begin
      n_fail++; $display("FAIL mul_done got v%b %h pc %h want v1 ffffff 200", bus.ow_valid, bus.ow_result, bus.ow_pc); end
    n_chk++; if (bus.ow_stall !== 1'b0) begin n_fail++; $display("FAIL mul_stall_drop got %b want 0", bus.ow_stall); end
    tick();
    bus.iw_valid = 1'b0;
    n_chk++; if (bus.ow_result !== 24'd3 || bus.ow_pc !== 24'h204) begin
      n_fail++; $display("FAIL held_add got %h pc %h want 3 204", bus.ow_result, bus.ow_pc); end
    drive(OPC_MULHU, 24'h000FFF, 24'h001001, 12'h0, 24'h000208, 24'h0);
    tick();
    bus.iw_valid = 1'b0;
    cyc = 0;
    do begin tick(); cyc++; end while (bus.ow_valid !== 1'b1 && cyc < 20);
    n_chk++; if (cyc != 6 || bus.ow_result !== 24'h000000) begin
      n_fail++; $display("FAIL mulhu got %h after %0d cycles want 0 after 6", bus.ow_result, cyc); end
  endtask

  task automatic test_mul_flush();
    drive(OPC_LUI, 24'h0, 24'h0, 12'h5A5, 24'h000300, 24'h0);
    tick();
    drive(OPC_MUL, 24'd3, 24'd4, 12'h0, 24'h000304, 24'h0);
    tick();
    bus.iw_valid = 1'b0;
    tick();
    tick();
    bus.iw_flush = 1'b1;
    tick();
    bus.iw_flush = 1'b0;
    n_chk++; if (bus.ow_stall !== 1'b0 || bus.ow_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_state got stall %b valid %b want 0 0", bus.ow_stall, bus.ow_valid); end
    n_chk++; if (bus.ow_result !== 24'h0 || bus.ow_pc !== 24'h300) begin
      n_fail++; $display("FAIL flush_hold got %h pc %h want 0 300", bus.ow_result, bus.ow_pc); end
    drive(OPC_ADD, 24'd10, 24'd20, 12'h0, 24'h000308, 24'h0);
    tick();
    n_chk++; if (bus.ow_valid !== 1'b1 || bus.ow_result !== 24'd30) begin
      n_fail++; $display("FAIL flush_next_add got v%b %h want v1 1e", bus.ow_valid, bus.ow_result); end
    drive(OPC_MOVI, 24'h0, 24'h0, 12'h005, 24'h00030C, 24'h0);
    tick();
    n_chk++; if (bus.ow_result !== 24'h000005) begin
      n_fail++; $display("FAIL flush_clears_ui got %h want 000005", bus.ow_result); end
    drive(OPC_ADD, 24'd1, 24'd1, 12'h0, 24'h000310, 24'h0);
    bus.iw_flush = 1'b1;
    tick();
    bus.iw_flush = 1'b0;
    bus.iw_valid = 1'b0;
    n_chk++; if (bus.ow_valid !== 1'b0 || bus.ow_result !== 24'h000005) begin
      n_fail++; $display("FAIL flush_drops_op got v%b %h want v0 000005", bus.ow_valid, bus.ow_result); end
    m_ui = 0;
  endtask

  task automatic test_shift_edge();
    logic [7:0]  ops  [6] = '{OPC_SHRS, OPC_SHR, OPC_SHL, OPC_MOVIS, OPC_SHRS, OPC_SHRIS};
    logic [23:0] ss   [6] = '{24'd4, 24'd4, 24'd24, 24'd0, 24'd24, 24'h800000};
    logic [23:0] ts   [6] = '{24'h800000, 24'h800000, 24'h000001, 24'h0, 24'h800000, 24'h0};
    logic [11:0] imms [6] = '{12'h0, 12'h0, 12'h0, 12'h800, 12'h0, 12'd31};
    logic [23:0] want [6] = '{24'hF80000, 24'h080000, 24'h000000, 24'hFFF800, 24'hFFFFFF, 24'hFFFFFF};
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], ss[i], ts[i], imms[i], 24'h400 + 24'(i), 24'h0);
      tick();
      n_chk++; if (bus.ow_result !== want[i]) begin
        n_fail++; $display("FAIL shift_edge%0d got %h want %h", i, bus.ow_result, want[i]); end
    end
    bus.iw_valid = 1'b0;
  endtask

  task automatic test_srmov_unknown();
    bus.iw_sr_val = 24'h777777;
    bus.iw_src_is_pc = 1'b1;
    drive(OPC_SRMOV, 24'h0, 24'h0, 12'h0, 24'h001234, 24'h0);
    tick();
    n_chk++; if (bus.ow_result !== 24'h001234) begin n_fail++; $display("FAIL srmov_pc got %h want 001234", bus.ow_result); end
    bus.iw_src_is_pc = 1'b0;
    tick();
    n_chk++; if (bus.ow_result !== 24'h777777) begin n_fail++; $display("FAIL srmov_sr got %h want 777777", bus.ow_result); end
    drive(8'hEE, 24'h123, 24'h456, 12'h0, 24'h000500, 24'h0);
    tick();
    bus.iw_valid = 1'b0;
    n_chk++; if (bus.ow_valid !== 1'b1 || bus.ow_result !== 24'h0) begin
      n_fail++; $display("FAIL unknown_op got v%b %h want v1 0", bus.ow_valid, bus.ow_result); end
  endtask

  task automatic test_random();
    logic [7:0] ops [29] = '{OPC_MOV, OPC_ADD, OPC_SUB, OPC_NOT, OPC_AND, OPC_OR, OPC_XOR, OPC_SHL,
      OPC_SHR, OPC_ADDS, OPC_SUBS, OPC_SHRS, OPC_MOVI, OPC_ADDI, OPC_SUBI, OPC_ANDI, OPC_ORI,
      OPC_XORI, OPC_SHLI, OPC_SHRI, OPC_MOVIS, OPC_ADDIS, OPC_SUBIS, OPC_SHRIS, OPC_LUI,
      OPC_SRMOV, OPC_MUL, OPC_MULHU, 8'h7F};
    logic [7:0] op;
    logic [23:0] s, t, pc, sr;
    logic [11:0] imm;
    logic isp;
    longint exp;
    int cyc;
    for (int n = 0; n < 80; n++) begin
      op  = ops[$urandom_range(0, 28)];
      s   = 24'($urandom);
      t   = 24'($urandom);
      if ($urandom_range(0, 1) == 1) s = 24'($urandom_range(0, 31));
      imm = 12'($urandom);
      pc  = 24'($urandom);
      sr  = 24'($urandom);
      isp = 1'($urandom);
      exp = ref_res(op, longint'(s), longint'(t), longint'(imm), longint'(sr), longint'(pc), isp, m_ui);
      if (op == OPC_LUI) m_ui = longint'(imm);
      else if (op >= OPC_MOVI && op <= OPC_XORI) m_ui = 0;
      bus.iw_sr_val = sr;
      bus.iw_src_is_pc = isp;
      drive(op, s, t, imm, pc, 24'(n));
      tick();
      bus.iw_valid = 1'b0;
      if (op == OPC_MUL || op == OPC_MULHU) begin
        cyc = 0;
        while (bus.ow_valid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
      end
      n_chk++; if (bus.ow_valid !== 1'b1 || bus.ow_result !== 24'(exp) || bus.ow_pc !== pc) begin
        n_fail++; $display("FAIL rand%0d op %h got v%b %h pc %h want v1 %h pc %h",
                           n, op, bus.ow_valid, bus.ow_result, bus.ow_pc, 24'(exp), pc); end
      if ($urandom_range(0, 3) == 0) begin
        tick();
        n_chk++; if (bus.ow_valid !== 1'b0) begin n_fail++; $display("FAIL rand_idle%0d got %b want 0", n, bus.ow_valid); end
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    drive(OPC_ADD, 24'd1, 24'd1, 12'h0, 24'h000600, 24'h000001);
    tick();
    drive(OPC_MUL, 24'h00ABCD, 24'h000123, 12'h0, 24'h000604, 24'h0);
    tick();
    bus.iw_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    n_chk++; if (bus.ow_valid !== 1'b0 || bus.ow_stall !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_ctl got valid %b stall %b want 0 0", bus.ow_valid, bus.ow_stall); end
    n_chk++; if (bus.ow_pc !== 24'h0 || bus.ow_instr !== 24'h0 || bus.ow_result !== 24'h0) begin
      n_fail++; $display("FAIL async_rst_data got pc %h instr %h res %h want 0", bus.ow_pc, bus.ow_instr, bus.ow_result); end
    @(negedge clk);
    rst = 1'b0;
    m_ui = 0;
    tick();
    tick();
    n_chk++; if (bus.ow_valid !== 1'b0 || bus.ow_stall !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_idle got valid %b stall %b want 0 0", bus.ow_valid, bus.ow_stall); end
  endtask

  initial begin
    test_reset();
    test_add_idle();
    test_lui();
    test_mul();
    test_mul_flush();
    test_shift_edge();
    test_srmov_unknown();
    test_random();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
